// File: rtl/rsa_core_scheduler.sv
// rsa_core_scheduler: arbitrates two requesters onto one RSA modexp core.
// Latches the owner's operands, restarts the core, and guards each run with a watchdog.
module rsa_core_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] p0,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] m0,
    input  logic [WIDTH-1:0] p1,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] m1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             core_rstb,
    output logic             core_ena,
    output logic [WIDTH-1:0] core_p,
    output logic [WIDTH-1:0] core_e,
    output logic [WIDTH-1:0] core_m,
    input  logic             core_eoc,
    input  logic [WIDTH-1:0] core_result
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, LOAD, CORE_RST, RUN, CAPTURE, DONE} state_t;

    state_t         state;
    logic           owner;
    logic           last;
    logic [WDW-1:0] wd;
    logic           pick;
    logic [1:0]     own_oh;
    logic           in_job;

    // On a tie the requester not served last wins.
    assign pick     = (req == 2'b11) ? ~last : req[1];
    assign own_oh   = owner ? 2'b10 : 2'b01;
    assign in_job   = state inside {LOAD, CORE_RST, RUN, CAPTURE};
    assign core_ena = ena & (state == RUN);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 1'b0;
            result    <= '0;
            core_rstb <= 1'b0;
            core_p    <= '0;
            core_e    <= '0;
            core_m    <= '0;
            wd        <= '0;
        end else if (ena) begin
            if (in_job && !req[owner]) begin
                state     <= IDLE;
                gnt       <= 2'b00;
                core_rstb <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        core_rstb <= 1'b0;
                        if (|req) begin
                            owner <= pick;
                            gnt   <= pick ? 2'b10 : 2'b01;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        core_p <= owner ? p1 : p0;
                        core_e <= owner ? e1 : e0;
                        core_m <= owner ? m1 : m0;
                        state  <= CORE_RST;
                    end
                    CORE_RST: begin
                        wd        <= '0;
                        core_rstb <= 1'b1;
                        state     <= RUN;
                    end
                    RUN: begin
                        wd <= wd + 1'b1;
                        if (core_eoc) begin
                            state <= CAPTURE;
                        end else if (wd == WDW'(TIMEOUT - 1)) begin
                            err       <= 1'b1;
                            result    <= '0;
                            done      <= own_oh;
                            core_rstb <= 1'b0;
                            state     <= DONE;
                        end
                    end
                    CAPTURE: begin
                        result    <= core_result;
                        err       <= 1'b0;
                        done      <= own_oh;
                        core_rstb <= 1'b0;
                        state     <= DONE;
                    end
                    DONE: begin
                        done      <= 2'b00;
                        last      <= owner;
                        gnt       <= 2'b00;
                        core_rstb <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        gnt       <= 2'b00;
                        done      <= 2'b00;
                        core_rstb <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
